// File: rtl/mem_stage_pipe.sv
// RV32I memory stage with byte-lane data memory, configurable wait states,
// and the MEM/WB pipeline register feeding writeback.
module mem_stage_pipe #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic        reg_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pc_plus4_m,
  output logic        stall_m,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [4:0]  rd_w,
  output logic [31:0] pc_plus4_w,
  output logic        fault_w
);

  localparam int unsigned AddrW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);
  localparam bit          HasWait = (WAIT_STATES != 0);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             access, illegal, misalign, fault, go, complete, we;
  logic [AddrW-1:0] idx;
  logic [1:0]       off;
  logic [3:0]       be;
  logic [31:0]      st_data, word, ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  assign access = mem_read_m | mem_write_m;
  assign idx    = alu_result_m[AddrW+1:2];
  assign off    = alu_result_m[1:0];

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (mem_read_m)  illegal = funct3_m inside {3'b011, 3'b110, 3'b111};
    if (mem_write_m) illegal = (funct3_m >= 3'b011);
    case (funct3_m[1:0])
      2'b01:   misalign = off[0];
      2'b10:   misalign = (off != 2'b00);
      default: misalign = 1'b0;
    endcase
    fault = access & (illegal | misalign);
  end

  assign go = access & ~fault;

  always_comb begin
    if (state_q == StIdle) stall_m = go & HasWait;
    else                   stall_m = (cnt_q < WaitCnt);
  end

  // M inputs are held while stalled, so the first unstalled cycle of a valid
  // access is its completion edge.
  assign complete = go & ~stall_m;
  assign we       = complete & mem_write_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (go && HasWait) begin
            state_q <= StWait;
            cnt_q   <= 4'd1;
          end
        end
        StWait: begin
          if (cnt_q == WaitCnt) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    be      = 4'b0000;
    st_data = write_data_m;
    case (funct3_m[1:0])
      2'b00: begin
        be      = 4'b0001 << off;
        st_data = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{write_data_m[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign word = mem_q[idx];

  always_comb begin
    case (off)
      2'b00:   ld_byte = word[7:0];
      2'b01:   ld_byte = word[15:8];
      2'b10:   ld_byte = word[23:16];
      default: ld_byte = word[31:24];
    endcase
    ld_half = off[1] ? word[31:16] : word[15:0];
    case (funct3_m)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_w  <= 1'b0;
      result_src_w <= 2'd0;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
      rd_w         <= 5'd0;
      pc_plus4_w   <= 32'd0;
      fault_w      <= 1'b0;
    end else if (stall_m) begin
      reg_write_w  <= 1'b0;
      result_src_w <= 2'd0;
      alu_result_w <= 32'd0;
      read_data_w  <= 32'd0;
      rd_w         <= 5'd0;
      pc_plus4_w   <= 32'd0;
      fault_w      <= 1'b0;
    end else begin
      reg_write_w  <= reg_write_m & ~fault;
      result_src_w <= result_src_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= (mem_read_m && !fault) ? ld_data : 32'd0;
      rd_w         <= rd_m;
      pc_plus4_w   <= pc_plus4_m;
      fault_w      <= fault;
    end
  end

endmodule
